// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Load/store unit front end for a 32-bit word-organised RAM. Accepts one
// byte/half/word request at a time, splits accesses that straddle a word
// boundary into two RAM cycles, aligns store data onto byte lanes, and
// reassembles, shifts and extends load data before returning a single-cycle
// response pulse.
//
// Ports
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   clk_en              global advance enable; all registers hold when low
//   i_req_*             request channel (valid/ready handshake, store flag,
//                       byte address, size, unsigned-load flag, store data)
//   o_resp_*            response pulse with extended load data and error flag
//   o_ram_read_*        RAM read port (combinational data return)
//   o_ram_write_*       RAM write port with per-byte lane enables
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,

    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH:0]   i_req_addr,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [31:0]           i_req_wdata,

    output logic                  o_resp_valid,
    output logic [31:0]           o_resp_rdata,
    output logic                  o_resp_err,

    output logic                  o_ram_read_req,
    output logic [ADDR_WIDTH:0]   o_ram_read_addr,
    input  logic [31:0]           i_ram_read_data,

    output logic                  o_ram_write_enable,
    output logic [3:0]            o_ram_byte_enable,
    output logic [ADDR_WIDTH:0]   o_ram_write_addr,
    output logic [31:0]           o_ram_write_data
);

    // Word index width: address bits [ADDR_WIDTH:2].
    localparam int WW = ADDR_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        ACC1,
        ACC2,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    // Latched request
    logic                req_we;
    logic [ADDR_WIDTH:0] req_addr;
    logic [1:0]          req_size;
    logic                req_unsigned;
    logic [31:0]         req_wdata;

    // Captured load words and error flag
    logic [31:0]         lo;
    logic [31:0]         hi;
    logic                resp_err;

    // Derived access geometry
    logic [1:0]          off;
    logic [5:0]          bit_shift;
    logic [WW-1:0]       word_lo;
    logic [WW-1:0]       word_hi;
    logic [7:0]          base_mask;
    logic [7:0]          mask8;
    logic                split;
    logic [63:0]         wide_wdata;
    logic [31:0]         load_shifted;
    logic [31:0]         load_result;

    assign off       = req_addr[1:0];
    assign bit_shift = {1'b0, off, 3'b000};
    assign word_lo   = req_addr[ADDR_WIDTH:2];
    // Natural overflow of the WW-bit sum gives the required wrap.
    assign word_hi   = word_lo + {{(WW-1){1'b0}}, 1'b1};

    always_comb begin
        base_mask = 8'h0F;
        case (req_size)
            2'b00:   base_mask = 8'h01;
            2'b01:   base_mask = 8'h03;
            default: base_mask = 8'h0F;
        endcase
    end

    assign mask8      = base_mask << off;
    assign split      = |mask8[7:4];
    assign wide_wdata = {32'b0, req_wdata} << bit_shift;

    // Low 32 bits of ({hi, lo} >> 8*off); a shift by 32 yields zero, which
    // covers the aligned case without a special branch.
    assign load_shifted = (lo >> bit_shift) | (hi << (6'd32 - bit_shift));

    always_comb begin
        load_result = load_shifted;
        case (req_size)
            2'b00: load_result = req_unsigned ? {24'b0, load_shifted[7:0]}
                                              : {{24{load_shifted[7]}}, load_shifted[7:0]};
            2'b01: load_result = req_unsigned ? {16'b0, load_shifted[15:0]}
                                              : {{16{load_shifted[15]}}, load_shifted[15:0]};
            default: load_result = load_shifted;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= next_state;
        end
    end

    // Next-state and all outputs; RAM and response outputs are zero unless
    // the current state explicitly drives them.
    always_comb begin
        next_state         = state;
        o_req_ready        = 1'b0;
        o_resp_valid       = 1'b0;
        o_resp_rdata       = 32'b0;
        o_resp_err         = 1'b0;
        o_ram_read_req     = 1'b0;
        o_ram_read_addr    = '0;
        o_ram_write_enable = 1'b0;
        o_ram_byte_enable  = 4'b0;
        o_ram_write_addr   = '0;
        o_ram_write_data   = 32'b0;

        case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    next_state = (i_req_size == 2'b11) ? RESP : ACC1;
                end
            end

            ACC1: begin
                o_ram_read_addr   = {2'b00, word_lo};
                o_ram_write_addr  = {2'b00, word_lo};
                o_ram_byte_enable = mask8[3:0];
                if (req_we) begin
                    o_ram_write_enable = 1'b1;
                    o_ram_write_data   = wide_wdata[31:0];
                end else begin
                    o_ram_read_req = 1'b1;
                end
                next_state = split ? ACC2 : RESP;
            end

            ACC2: begin
                o_ram_read_addr   = {2'b00, word_hi};
                o_ram_write_addr  = {2'b00, word_hi};
                o_ram_byte_enable = mask8[7:4];
                if (req_we) begin
                    o_ram_write_enable = 1'b1;
                    o_ram_write_data   = wide_wdata[63:32];
                end else begin
                    o_ram_read_req = 1'b1;
                end
                next_state = RESP;
            end

            RESP: begin
                o_resp_valid = 1'b1;
                o_resp_err   = resp_err;
                o_resp_rdata = (req_we || resp_err) ? 32'b0 : load_result;
                next_state   = IDLE;
            end

            default: next_state = IDLE;
        endcase
    end

    // Request latch and load capture. lo/hi are cleared on acceptance so an
    // unsplit load sees hi = 0 and stores/errors return zero data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_we       <= 1'b0;
            req_addr     <= '0;
            req_size     <= 2'b00;
            req_unsigned <= 1'b0;
            req_wdata    <= 32'b0;
            lo           <= 32'b0;
            hi           <= 32'b0;
            resp_err     <= 1'b0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        req_we       <= i_req_we;
                        req_addr     <= i_req_addr;
                        req_size     <= i_req_size;
                        req_unsigned <= i_req_unsigned;
                        req_wdata    <= i_req_wdata;
                        lo           <= 32'b0;
                        hi           <= 32'b0;
                        resp_err     <= (i_req_size == 2'b11);
                    end
                end
                ACC1: begin
                    if (!req_we) begin
                        lo <= i_ram_read_data;
                    end
                end
                ACC2: begin
                    if (!req_we) begin
                        hi <= i_ram_read_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//
// Scoreboard bench for lsu_mem_ctrl. A byte-addressed reference memory
// predicts every response at acceptance time; a monitor pops and compares
// whenever the DUT raises o_resp_valid. A directed section probes the RAM
// port for the documented example accesses, clock-enable stall and reset
// abort; a randomized section then exercises all sizes, offsets and the
// top-of-address wrap with random clk_en stalls.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

    localparam int AW = 31;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_en = 1'b1;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic          i_req_we = 1'b0;
    logic [AW:0]   i_req_addr = '0;
    logic [1:0]    i_req_size = 2'b00;
    logic          i_req_unsigned = 1'b0;
    logic [31:0]   i_req_wdata = 32'b0;
    logic          o_resp_valid;
    logic [31:0]   o_resp_rdata;
    logic          o_resp_err;
    logic          o_ram_read_req;
    logic [AW:0]   o_ram_read_addr;
    logic [31:0]   i_ram_read_data;
    logic          o_ram_write_enable;
    logic [3:0]    o_ram_byte_enable;
    logic [AW:0]   o_ram_write_addr;
    logic [31:0]   o_ram_write_data;

    lsu_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk                (clk),
        .rst                (rst),
        .clk_en             (clk_en),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .i_req_we           (i_req_we),
        .i_req_addr         (i_req_addr),
        .i_req_size         (i_req_size),
        .i_req_unsigned     (i_req_unsigned),
        .i_req_wdata        (i_req_wdata),
        .o_resp_valid       (o_resp_valid),
        .o_resp_rdata       (o_resp_rdata),
        .o_resp_err         (o_resp_err),
        .o_ram_read_req     (o_ram_read_req),
        .o_ram_read_addr    (o_ram_read_addr),
        .i_ram_read_data    (i_ram_read_data),
        .o_ram_write_enable (o_ram_write_enable),
        .o_ram_byte_enable  (o_ram_byte_enable),
        .o_ram_write_addr   (o_ram_write_addr),
        .o_ram_write_data   (o_ram_write_data)
    );

    always #5 clk = ~clk;

    // RAM seen by the DUT: 16 words, aliased on the low word-index bits
    logic [31:0] ram [16];
    assign i_ram_read_data = ram[o_ram_read_addr[3:0]];

    int write_count = 0;
    always @(posedge clk) begin
        if (clk_en && o_ram_write_enable) begin
            for (int k = 0; k < 4; k++) begin
                if (o_ram_byte_enable[k]) begin
                    ram[o_ram_write_addr[3:0]][8*k +: 8] <= o_ram_write_data[8*k +: 8];
                end
            end
            write_count <= write_count + 1;
        end
    end

    // Count of enabled clock edges, used to measure latency in advancing cycles
    int en_cycle = 0;
    always @(posedge clk) begin
        if (clk_en) en_cycle <= en_cycle + 1;
    end

    // Random clk_en, changed away from both clock edges
    logic en_random = 1'b0;
    always @(posedge clk) begin
        if (en_random) begin
            #2;
            clk_en = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference model: flat byte memory, 64 bytes, little-endian
    logic [7:0] ref_mem [64];
    logic [7:0] ref_save [64];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic probeRam(input string tag, input logic re, input logic we,
                            input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        checkOutput({tag, "_read_req"},     {31'b0, o_ram_read_req},     {31'b0, re});
        checkOutput({tag, "_write_enable"}, {31'b0, o_ram_write_enable}, {31'b0, we});
        checkOutput({tag, "_read_addr"},    o_ram_read_addr,             addr);
        checkOutput({tag, "_write_addr"},   o_ram_write_addr,            addr);
        checkOutput({tag, "_byte_enable"},  {28'b0, o_ram_byte_enable},  {28'b0, be});
        if (we) checkOutput({tag, "_write_data"}, o_ram_write_data, wd);
    endtask

    // Issue one request starting at a negedge; predicts its response from
    // the reference memory and returns at the negedge after acceptance.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata);
        exp_t        e;
        int          n;
        int          guard;
        logic [31:0] val;
        logic [5:0]  bi;
        i_req_we       = we;
        i_req_addr     = addr;
        i_req_size     = size;
        i_req_unsigned = uns;
        i_req_wdata    = wdata;
        i_req_valid    = 1'b1;
        guard = 0;
        while (!(o_req_ready && clk_en) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_accept_timeout: ready=%0b required 1", o_req_ready);
            i_req_valid = 1'b0;
            return;
        end
        if (size == 2'b11) begin
            e.rdata = 32'b0;
            e.err   = 1'b1;
            e.lat   = 1;
        end else begin
            n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
            e.err = 1'b0;
            e.lat = (int'(addr[1:0]) + n > 4) ? 3 : 2;
            val = 32'b0;
            for (int i = 0; i < n; i++) begin
                bi = addr[5:0] + 6'(i);
                if (we) ref_mem[bi] = wdata[8*i +: 8];
                else    val[8*i +: 8] = ref_mem[bi];
            end
            if (!we && !uns && n < 4 && val[8*n-1]) begin
                for (int i = n; i < 4; i++) val[8*i +: 8] = 8'hFF;
            end
            e.rdata = we ? 32'b0 : val;
        end
        e.acc = en_cycle + 1;
        sb.push_back(e);
        @(negedge clk);
        i_req_valid = 1'b0;
    endtask

    // Response monitor
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            prev_valid = 1'b0;
        end else begin
            if (o_resp_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_resp: rdata=0x%08h err=%0b with no request pending",
                             o_resp_rdata, o_resp_err);
                end else begin
                    e = sb.pop_front();
                    checkOutput("resp_rdata", o_resp_rdata, e.rdata);
                    checkOutput("resp_err", {31'b0, o_resp_err}, {31'b0, e.err});
                    checkOutput("resp_latency", 32'(en_cycle - e.acc + 1), 32'(e.lat));
                end
            end
            prev_valid = o_resp_valid;
        end
    end

    initial begin
        int wc0;
        int guard;
        logic [31:0] addr;

        for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'(8'h11 * (i + 1));
        for (int w = 0; w < 16; w++)
            ram[w] = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};

        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("reset_req_ready",  {31'b0, o_req_ready},  32'd1);
        checkOutput("reset_resp_valid", {31'b0, o_resp_valid}, 32'd0);
        checkOutput("reset_resp_rdata", o_resp_rdata,          32'd0);
        checkOutput("reset_resp_err",   {31'b0, o_resp_err},   32'd0);
        checkOutput("reset_write_data", o_ram_write_data,      32'd0);
        probeRam("reset", 1'b0, 1'b0, 32'd0, 4'b0000, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] directed accesses");
        wc0 = write_count;
        applyStimulus(1'b1, 32'h8, 2'b10, 1'b0, 32'hDEADBEEF);
        probeRam("st_word", 1'b0, 1'b1, 32'd2, 4'b1111, 32'hDEADBEEF);
        @(negedge clk);
        probeRam("st_word_resp", 1'b0, 1'b0, 32'd0, 4'b0000, 32'd0);
        checkOutput("st_word_writes", 32'(write_count - wc0), 32'd1);

        applyStimulus(1'b0, 32'h7, 2'b00, 1'b0, 32'd0);
        probeRam("ld_byte_s", 1'b1, 1'b0, 32'd1, 4'b1000, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 32'h7, 2'b00, 1'b1, 32'd0);
        probeRam("ld_byte_u", 1'b1, 1'b0, 32'd1, 4'b1000, 32'd0);
        @(negedge clk);

        applyStimulus(1'b0, 32'h2, 2'b10, 1'b0, 32'd0);
        probeRam("ld_split_lo", 1'b1, 1'b0, 32'd0, 4'b1100, 32'd0);
        @(negedge clk);
        probeRam("ld_split_hi", 1'b1, 1'b0, 32'd1, 4'b0011, 32'd0);
        @(negedge clk);

        applyStimulus(1'b1, 32'h3, 2'b01, 1'b0, 32'h0000BBAA);
        probeRam("st_split_lo", 1'b0, 1'b1, 32'd0, 4'b1000, 32'hAA000000);
        @(negedge clk);
        probeRam("st_split_hi", 1'b0, 1'b1, 32'd1, 4'b0001, 32'h000000BB);
        @(negedge clk);

        applyStimulus(1'b1, 32'h4, 2'b11, 1'b0, 32'hFFFFFFFF);
        probeRam("err", 1'b0, 1'b0, 32'd0, 4'b0000, 32'd0);
        checkOutput("err_resp_valid", {31'b0, o_resp_valid}, 32'd1);
        @(negedge clk);

        $display("[TB] clock-enable stall");
        applyStimulus(1'b0, 32'h1, 2'b10, 1'b1, 32'd0);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            probeRam("hold", 1'b1, 1'b0, 32'd0, 4'b1110, 32'd0);
            checkOutput("hold_resp_valid", {31'b0, o_resp_valid}, 32'd0);
        end
        clk_en = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] reset during split store");
        ref_save = ref_mem;
        wc0 = write_count;
        applyStimulus(1'b1, 32'h3, 2'b01, 1'b0, 32'h00007766);
        checkOutput("abort_acc1_we", {31'b0, o_ram_write_enable}, 32'd1);
        #1 rst = 1'b0;
        #1;
        checkOutput("abort_we_drop", {31'b0, o_ram_write_enable}, 32'd0);
        checkOutput("abort_be_drop", {28'b0, o_ram_byte_enable},  32'd0);
        checkOutput("abort_ready",   {31'b0, o_req_ready},        32'd1);
        ref_mem = ref_save;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("abort_writes", 32'(write_count - wc0), 32'd0);
        checkOutput("abort_ready_after", {31'b0, o_req_ready}, 32'd1);

        $display("[TB] randomized traffic");
        en_random = 1'b1;
        for (int t = 0; t < 300; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFFFFC0 | 32'($urandom_range(0, 63));
            else                          addr = 32'($urandom_range(0, 63));
            applyStimulus(1'($urandom_range(0, 1)), addr, 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), $urandom);
        end
        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
        end
        en_random = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 31, MSB index of every address bus, so buses are [ADDR_WIDTH:0].
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- clk_en  in  1  global advance enable.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted when valid & ready at a clk_en edge.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  ADDR_WIDTH+1  byte address.
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- i_req_unsigned  in  1  zero-extend loads.
- i_req_wdata  in  32  store data, right-aligned.
- o_resp_valid  out  1  one-cycle completion pulse.
- o_resp_rdata  out  32  extended load data; 0 for stores and errors.
- o_resp_err  out  1  illegal size.
- o_ram_read_req  out  1  RAM read request.
- o_ram_read_addr  out  ADDR_WIDTH+1  RAM word index.
- i_ram_read_data  in  32  RAM data, combinational from o_ram_read_addr.
- o_ram_write_enable  out  1  RAM write.
- o_ram_byte_enable  out  4  RAM lane enables; bit k = bits [8k+7:8k].
- o_ram_write_addr  out  ADDR_WIDTH+1  RAM word index.
- o_ram_write_data  out  32  RAM write data.

Function
REQ-003 SHALL implement FSM states IDLE, ACC1, ACC2, RESP; o_req_ready = 1 only in IDLE.
REQ-004 SHALL hold every register when clk_en = 0.
REQ-005 On acceptance SHALL latch we, addr, size, unsigned and wdata, then go to ACC1, or to RESP with err = 1 if size = 11.
REQ-006 SHALL define off = addr[1:0], W = addr[ADDR_WIDTH:2] zero-extended, and mask8 = {0001, 0011, 1111}[size] << off as 8 bits.
REQ-007 SHALL mark a request split when mask8[7:4] != 0; split requests go ACC1 -> ACC2 -> RESP, others go ACC1 -> RESP.
REQ-008 ACC1 SHALL target word W with byte enables mask8[3:0]; ACC2 SHALL target W+1, wrapping modulo 2^(ADDR_WIDTH-1), with mask8[7:4].
REQ-009 Stores: in ACC1/ACC2, o_ram_write_enable = 1 and o_ram_write_data is the low/high half of the 64-bit value ({32'b0, wdata} << 8*off).
REQ-010 Loads: in ACC1/ACC2, o_ram_read_req = 1 and i_ram_read_data is registered as lo (ACC1) or hi (ACC2).
REQ-011 Load result SHALL be ({hi, lo} >> 8*off) truncated to the size, then sign-extended unless unsigned; hi = 0 when not split.
REQ-012 Outside ACC states SHALL drive read_req = 0, write_enable = 0, byte_enable = 0, and data/addresses = 0; read and write addresses are equal in ACC states.
REQ-013 In RESP SHALL assert o_resp_valid = 1 with registered rdata and err for exactly one cycle, then go unconditionally to IDLE; there is no response backpressure.
REQ-014 Latency from the acceptance edge to o_resp_valid SHALL be: error 1 cycle, unsplit 2 cycles, split 3 cycles.
REQ-015 A request presented in RESP SHALL wait and be accepted in the following IDLE cycle.

Reset
REQ-016 rst = 0 SHALL immediately force IDLE and set o_req_ready = 1, all other outputs = 0, and lo/hi = 0.
REQ-017 Reset mid-access SHALL abort the access: no further RAM write and no response; the abandoned request is not replayed.

Verification
REQ-018 RAM word0 = 0x44332211, word1 = 0x88776655; store word at 0x8 with data 0xDEADBEEF -> one write, addr 2, be 1111, data 0xDEADBEEF; resp at T+2, err 0.
REQ-019 Byte load at 0x7: signed -> rdata 0xFFFFFF88; unsigned -> 0x00000088; one read, addr 1.
REQ-020 Word load at 0x2 -> reads of addr 0 then 1, rdata 0x66554433, resp at T+3.
REQ-021 Half store at 0x3 with data 0x0000BBAA -> write addr 0, be 1000, data 0xAA000000; then addr 1, be 0001, data 0x000000BB.
REQ-022 size = 11 -> no RAM enables; resp at T+1 with err 1 and rdata 0. Also: clk_en = 0 for 3 cycles in ACC1 -> state and outputs hold.
REQ-023 rst = 0 during ACC1 of a split store -> write_enable drops immediately, no ACC2 write and no response; o_req_ready = 1 once rst = 1.
